// File: rtl/led_vu_meter.sv
// Stereo peak meter: takes the equalizer output samples and drives the board LEDs
// as a log-scale bar graph with peak hold, exponential decay and a clip indicator.
module led_vu_meter #(
    parameter int HOLD_SAMPLES = 2048,
    parameter int DECAY_SHIFT  = 6,
    parameter int CLIP_HOLD    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [15:0] lft_out,
    input  logic [15:0] rht_out,
    input  logic        en,
    output logic [7:0]  LED,
    output logic        clip
);

    localparam int CNT_MAX = (HOLD_SAMPLES > CLIP_HOLD) ? HOLD_SAMPLES : CLIP_HOLD;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [14:0]     peak;
    logic [14:0]     peak_next;
    logic [CW-1:0]   hold_cnt;
    logic [CW-1:0]   hold_next;
    logic [CW-1:0]   clip_cnt;
    logic [CW-1:0]   clip_next;

    logic            s1_vld;
    logic [14:0]     mag_l;
    logic [14:0]     mag_r;
    logic            sat_flag;

    logic [14:0]     mag;
    logic [14:0]     dec;
    logic [14:0]     diff;
    logic [7:0]      led_next;
    logic            clip_flag_next;

    logic            clear;

    assign clear = rst || !en;

    // Magnitude of a two's complement sample; the most negative code saturates.
    function automatic logic [14:0] magnitude(input logic [15:0] s);
        logic [15:0] neg;
        neg = -s;
        if (s == 16'h8000)
            return 15'h7FFF;
        else if (s[15])
            return neg[14:0];
        else
            return s[14:0];
    endfunction

    function automatic logic is_full_scale(input logic [15:0] s);
        return (s == 16'h7FFF) || (s == 16'h8000);
    endfunction

    // Stage 1: rectify both channels and flag full-scale samples.
    always_ff @(posedge clk) begin
        if (clear) begin
            s1_vld   <= 1'b0;
            mag_l    <= '0;
            mag_r    <= '0;
            sat_flag <= 1'b0;
        end else begin
            s1_vld <= valid;
            if (valid) begin
                mag_l    <= magnitude(lft_out);
                mag_r    <= magnitude(rht_out);
                sat_flag <= is_full_scale(lft_out) || is_full_scale(rht_out);
            end
        end
    end

    // Stage 2 state: peak FSM, hold/clip timers and the registered LED outputs.
    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= IDLE;
            peak     <= '0;
            hold_cnt <= '0;
            clip_cnt <= '0;
            LED      <= 8'h00;
            clip     <= 1'b0;
        end else begin
            state    <= state_next;
            peak     <= peak_next;
            hold_cnt <= hold_next;
            clip_cnt <= clip_next;
            LED      <= led_next;
            clip     <= clip_flag_next;
        end
    end

    always_comb begin
        state_next = state;
        peak_next  = peak;
        hold_next  = hold_cnt;
        clip_next  = clip_cnt;

        mag  = (mag_l > mag_r) ? mag_l : mag_r;
        dec  = peak >> DECAY_SHIFT;
        if (dec == 15'd0 && peak != 15'd0)
            dec = 15'd1;
        diff = peak - dec;

        if (s1_vld) begin
            if (sat_flag)
                clip_next = CW'(CLIP_HOLD);
            else if (clip_cnt != '0)
                clip_next = clip_cnt - CW'(1);

            // Attack is instantaneous; equality is deliberately not an attack.
            if (mag > peak) begin
                peak_next  = mag;
                hold_next  = CW'(HOLD_SAMPLES - 1);
                state_next = HOLD;
            end else begin
                case (state)
                    HOLD: begin
                        if (hold_cnt != '0)
                            hold_next = hold_cnt - CW'(1);
                        else
                            state_next = DECAY;
                    end
                    DECAY: begin
                        peak_next = (diff > mag) ? diff : mag;
                        if (peak_next == 15'd0)
                            state_next = IDLE;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Thermometer bar from the updated peak; the top LED doubles as clip indicator.
    always_comb begin
        led_next = 8'h00;
        for (int k = 0; k < 8; k++)
            led_next[k] = ({1'b0, peak_next} >= (16'd128 << k));
        clip_flag_next = (clip_next != '0);
        if (clip_flag_next)
            led_next[7] = 1'b1;
    end

endmodule

// File: tb/tb_led_vu_meter.sv
// Directed self-checking bench for led_vu_meter: latency, hold/decay timing,
// clip timer, equality-is-not-attack, and enable/reset abort.
module tb_led_vu_meter;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [15:0] lft_out;
    logic [15:0] rht_out;
    logic        en;
    logic [7:0]  LED;
    logic        clip;

    int total;
    int passed;

    led_vu_meter dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .lft_out (lft_out),
        .rht_out (rht_out),
        .en      (en),
        .LED     (LED),
        .clip    (clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One sample captured on the next rising edge; returns at the following falling edge.
    task automatic send(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        valid   = 1'b1;
        lft_out = l;
        rht_out = r;
        @(negedge clk);
        valid   = 1'b0;
        lft_out = 16'h0000;
        rht_out = 16'h0000;
    endtask

    task automatic send_zeros(input int n);
        @(negedge clk);
        valid   = 1'b1;
        lft_out = 16'h0000;
        rht_out = 16'h0000;
        repeat (n) @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int p;
        int d;
        int steps;
        int p_before_last;

        total   = 0;
        passed  = 0;
        rst     = 1'b0;
        en      = 1'b1;
        valid   = 1'b0;
        lft_out = 16'h0000;
        rht_out = 16'h0000;

        // Reset then idle
        do_reset();
        repeat (3) @(negedge clk);
        check("reset_led", 32'(LED), 32'h00);
        check("reset_clip", 32'(clip), 0);
        check("reset_peak", 32'(dut.peak), 0);
        repeat (20) @(negedge clk);
        check("idle_led", 32'(LED), 32'h00);

        // Attack with two-cycle latency, |-1000| = 1000 -> 3 bars
        send(16'd300, -16'sd1000);
        check("attack_not_early", 32'(LED), 32'h00);
        settle();
        check("attack_led", 32'(LED), 32'h07);
        check("attack_peak_abs", 32'(dut.peak), 1000);
        check("attack_state_hold", 32'(dut.state), 1);

        // Back-to-back samples with no gap
        do_reset();
        @(negedge clk);
        valid = 1'b1; lft_out = 16'd1000; rht_out = 16'd0;
        @(negedge clk);
        lft_out = 16'd3000;
        @(negedge clk);
        valid = 1'b0; lft_out = 16'd0;
        check("b2b_first", 32'(LED), 32'h07);
        settle();
        check("b2b_second", 32'(LED), 32'h1F);

        // Hold for 2048 samples, then decay
        do_reset();
        send(16'd16384, 16'd0);
        settle();
        check("hold_attack_led", 32'(LED), 32'hFF);
        send_zeros(2048);
        settle();
        check("hold_end_led", 32'(LED), 32'hFF);
        check("hold_end_peak", 32'(dut.peak), 16384);
        check("hold_end_state", 32'(dut.state), 2);
        send_zeros(1);
        settle();
        check("decay_first_led", 32'(LED), 32'h7F);
        check("decay_first_peak", 32'(dut.peak), 16128);

        p = 16128;
        steps = 0;
        p_before_last = p;
        while (p != 0) begin
            d = p >> 6;
            if (d == 0) d = 1;
            p_before_last = p;
            p = p - d;
            steps++;
        end
        send_zeros(steps - 1);
        settle();
        check("decay_pre_idle_peak", 32'(dut.peak), 32'(p_before_last));
        check("decay_pre_idle_state", 32'(dut.state), 2);
        send_zeros(1);
        settle();
        check("decay_idle_peak", 32'(dut.peak), 0);
        check("decay_idle_state", 32'(dut.state), 0);
        check("decay_idle_led", 32'(LED), 32'h00);

        // Clip timer on the most negative code
        do_reset();
        send(16'h8000, 16'd0);
        settle();
        check("clip_set", 32'(clip), 1);
        check("clip_led", 32'(LED), 32'hFF);
        check("clip_peak_sat", 32'(dut.peak), 32767);
        send_zeros(4095);
        settle();
        check("clip_held", 32'(clip), 1);
        check("clip_led7_held", 32'(LED[7]), 1);
        send_zeros(1);
        settle();
        check("clip_dropped", 32'(clip), 0);

        do_reset();
        send(16'd0, 16'h7FFF);
        settle();
        check("clip_pos_full", 32'(clip), 1);

        // Equality with the decayed peak is not an attack
        do_reset();
        send(16'd5000, 16'd0);
        settle();
        check("eq_attack_led", 32'(LED), 32'h3F);
        send_zeros(2048);
        settle();
        check("eq_in_decay", 32'(dut.state), 2);
        send(16'd4922, 16'd0);
        settle();
        check("eq_peak", 32'(dut.peak), 4922);
        check("eq_no_reload", 32'(dut.state), 2);
        send_zeros(1);
        settle();
        check("eq_decay_continues", 32'(dut.peak), 4846);

        // Enable low overrides a simultaneous sample
        do_reset();
        send(16'd20000, 16'd0);
        settle();
        check("en_pre_led", 32'(LED), 32'hFF);
        @(negedge clk);
        en = 1'b0; valid = 1'b1; lft_out = 16'd20000;
        @(negedge clk);
        en = 1'b1; valid = 1'b0; lft_out = 16'd0;
        check("en_blank_led", 32'(LED), 32'h00);
        settle();
        check("en_no_leak", 32'(LED), 32'h00);
        send(16'd200, 16'd0);
        settle();
        check("en_resume_led", 32'(LED), 32'h01);

        // Same with reset
        send(16'd20000, 16'd0);
        settle();
        check("rst_pre_led", 32'(LED), 32'hFF);
        @(negedge clk);
        rst = 1'b1; valid = 1'b1; lft_out = 16'd20000;
        @(negedge clk);
        rst = 1'b0; valid = 1'b0; lft_out = 16'd0;
        check("rst_blank_led", 32'(LED), 32'h00);
        settle();
        check("rst_no_leak", 32'(LED), 32'h00);
        send(16'd200, 16'd0);
        settle();
        check("rst_resume_led", 32'(LED), 32'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
